serial_parity_frame_ctrl: RTL

//   Transmit-side sequencer for the serial parity path. Accepts parallel words over a

---
 rtl/serial_parity_frame_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_parity_frame_ctrl.sv
// serial_parity_frame_ctrl: transmit-side frame sequencer for the serial parity path.
// Serialises each accepted word LSB first as start(0), DATA_W data bits, parity, stop(1),
// then GAP_CYC idle cycles. Tracks the running data-bit parity (z) and a frame counter.
// Optional build macro: ODD_PARITY_EN (parity bit = ~z, odd parity); default is even parity.
`timescale 1ns/1ps
module serial_parity_frame_ctrl #(
   parameter int DATA_W  = 8,
   parameter int GAP_CYC = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              x,
   output logic              bit_en,
   output logic              z,
   output logic              busy,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam int IW = (DATA_W > 1)  ? $clog2(DATA_W)  : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_GAP    = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IW-1:0]     idx_q,   idx_d;
   logic [GW-1:0]     gap_q,   gap_d;
   logic              z_q,     z_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   // Held low through reset and until the first edge after release, so din_ready
   // stays low while rst is asserted even though the state is already IDLE.
   logic              armed_q;
   logic              par_bit;

`ifdef ODD_PARITY_EN
   assign par_bit = ~z_q;
`else
   assign par_bit = z_q;
`endif

   // Next-state and datapath update for the frame sequencer
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (din_valid && din_ready) begin
               shift_d = din;
               idx_d   = '0;
               z_d     = 1'b0;
               state_d = S_START;
            end
         end
         S_START: state_d = S_DATA;
         S_DATA: begin
            shift_d = shift_q >> 1;
            z_d     = z_q ^ shift_q[0];
            if (idx_q == IW'(DATA_W - 1)) begin
               state_d = S_PARITY;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_PARITY: state_d = S_STOP;
         S_STOP: begin
            cnt_d = cnt_q + 1'b1;
            gap_d = '0;
            if (GAP_CYC == 0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == GW'(GAP_CYC - 1)) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers, async active-high reset drops any in-flight frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         z_q     <= 1'b0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         armed_q <= 1'b1;
      end
   end

   // Output decode from registered state only
   always_comb begin
      case (state_q)
         S_START:  x = 1'b0;
         S_DATA:   x = shift_q[0];
         S_PARITY: x = par_bit;
         default:  x = 1'b1;
      endcase
      bit_en     = (state_q == S_DATA);
      busy       = (state_q != S_IDLE);
      frame_done = (state_q == S_STOP);
      din_ready  = armed_q && (state_q == S_IDLE);
      z          = z_q;
      frame_cnt  = cnt_q;
   end

endmodule
